// File: rtl/second_level_decoder.sv
// Second-level GF(2^4) decoder: 8 data + 4 parity symbols, single-symbol correction
// with a sequential one-column-per-cycle error-location search.
module second_level_decoder #(
    parameter bit DUE_PASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0][3:0]  in_vp,
    input  logic [3:0][3:0]  in_pp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0][3:0]  out_vp,
    output logic [3:0][3:0]  out_pp,
    output logic             out_ce,
    output logic             out_due,
    output logic [3:0]       out_err_pos
);

    typedef enum logic [1:0] {IDLE, SYND, SEARCH, OUT} state_t;

    // Parity-check matrix, C[pp index][vp index]
    localparam logic [3:0] C [4][8] = '{
        '{4'd12, 4'd7,  4'd13, 4'd8,  4'd7,  4'd2,  4'd2,  4'd13},
        '{4'd13, 4'd9,  4'd9,  4'd15, 4'd13, 4'd14, 4'd11, 4'd12},
        '{4'd8,  4'd15, 4'd10, 4'd3,  4'd13, 4'd6,  4'd5,  4'd8},
        '{4'd6,  4'd5,  4'd13, 4'd6,  4'd14, 4'd14, 4'd5,  4'd7}
    };
    // Multiplicative inverses of row 0, used to recover the error magnitude
    localparam logic [3:0] INV0 [8] = '{4'd10, 4'd6, 4'd4, 4'd15, 4'd6, 4'd9, 4'd9, 4'd4};

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] x;
        r = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ x;
            x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
        end
        return r;
    endfunction

    state_t          r_state, w_next;
    logic [7:0][3:0] r_vp;
    logic [3:0][3:0] r_pp;
    logic [3:0][3:0] r_s;
    logic [3:0][3:0] w_s;
    logic [2:0]      r_col;
    logic            r_ce, r_due;
    logic [3:0]      r_pos;
    logic [3:0]      w_nz;
    logic            w_zero, w_one;
    logic [1:0]      w_idx;
    logic            w_match;
    logic [3:0]      w_e;

    always_comb begin
        w_s   = r_pp;
        w_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++)
                w_s[i] = w_s[i] ^ gf_mul(C[i][j], r_vp[j]);
            w_nz[i] = |w_s[i];
            if (w_nz[i]) w_idx = 2'(i);
        end
        w_zero = ~|w_nz;
        w_one  = $onehot(w_nz);
    end

    // Column r_col matches when the syndrome is proportional to that column
    always_comb begin
        w_match = |r_s[0];
        for (int k = 1; k < 4; k++)
            if (gf_mul(r_s[k], C[0][r_col]) != gf_mul(r_s[0], C[k][r_col]))
                w_match = 1'b0;
        w_e = gf_mul(r_s[0], INV0[r_col]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = SYND;
            end
            SYND:   w_next = (w_zero || w_one) ? OUT : SEARCH;
            SEARCH: if (w_match || r_col == 3'd7) w_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vp  <= '0;
            r_pp  <= '0;
            r_s   <= '0;
            r_col <= 3'd0;
            r_ce  <= 1'b0;
            r_due <= 1'b0;
            r_pos <= 4'd15;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_vp  <= in_vp;
                    r_pp  <= in_pp;
                    r_ce  <= 1'b0;
                    r_due <= 1'b0;
                    r_pos <= 4'd15;
                end
                SYND: begin
                    r_s   <= w_s;
                    r_col <= 3'd0;
                    if (w_one) begin
                        r_pp[w_idx] <= r_pp[w_idx] ^ w_s[w_idx];
                        r_ce        <= 1'b1;
                        r_pos       <= {2'b10, w_idx};
                    end
                end
                SEARCH: begin
                    if (w_match) begin
                        r_vp[r_col] <= r_vp[r_col] ^ w_e;
                        r_ce        <= 1'b1;
                        r_pos       <= {1'b0, r_col};
                    end else if (r_col == 3'd7) begin
                        r_due <= 1'b1;
                        if (!DUE_PASS) begin
                            r_vp <= '0;
                            r_pp <= '0;
                        end
                    end else begin
                        r_col <= r_col + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_vp      = r_vp;
    assign out_pp      = r_pp;
    assign out_ce      = r_ce;
    assign out_due     = r_due;
    assign out_err_pos = r_pos;

endmodule

// File: tb/tb_second_level_decoder.sv
// Directed bench for second_level_decoder; one instance per DUE_PASS setting.
module tb_second_level_decoder;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [7:0][3:0] in_vp = '0;
    logic [3:0][3:0] in_pp = '0;

    logic            p_in_ready, p_out_valid, p_ce, p_due;
    logic [7:0][3:0] p_vp;
    logic [3:0][3:0] p_pp;
    logic [3:0]      p_pos;
    logic            z_in_ready, z_out_valid, z_ce, z_due;
    logic [7:0][3:0] z_vp;
    logic [3:0][3:0] z_pp;
    logic [3:0]      z_pos;

    int checks = 0;
    int failures = 0;

    logic [3:0] C [4][8] = '{
        '{4'd12, 4'd7,  4'd13, 4'd8,  4'd7,  4'd2,  4'd2,  4'd13},
        '{4'd13, 4'd9,  4'd9,  4'd15, 4'd13, 4'd14, 4'd11, 4'd12},
        '{4'd8,  4'd15, 4'd10, 4'd3,  4'd13, 4'd6,  4'd5,  4'd8},
        '{4'd6,  4'd5,  4'd13, 4'd6,  4'd14, 4'd14, 4'd5,  4'd7}
    };

    always #5 clk = ~clk;

    second_level_decoder #(.DUE_PASS(1'b1)) dut_p (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(p_in_ready),
        .in_vp(in_vp), .in_pp(in_pp), .out_valid(p_out_valid), .out_ready(out_ready),
        .out_vp(p_vp), .out_pp(p_pp), .out_ce(p_ce), .out_due(p_due), .out_err_pos(p_pos)
    );

    second_level_decoder #(.DUE_PASS(1'b0)) dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
        .in_vp(in_vp), .in_pp(in_pp), .out_valid(z_out_valid), .out_ready(out_ready),
        .out_vp(z_vp), .out_pp(z_pp), .out_ce(z_ce), .out_due(z_due), .out_err_pos(z_pos)
    );

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] x;
        r = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ x;
            x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [3:0][3:0] parity(input logic [7:0][3:0] vp);
        logic [3:0][3:0] pp;
        pp = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 8; j++)
                pp[i] = pp[i] ^ gmul(C[i][j], vp[j]);
        return pp;
    endfunction

    // Brute force: is s explained by at most one symbol error anywhere?
    function automatic bit correctable(input logic [3:0][3:0] s);
        int nz;
        bit hit;
        nz = 0;
        for (int i = 0; i < 4; i++) if (s[i] != 4'h0) nz++;
        if (nz <= 1) return 1'b1;
        for (int j = 0; j < 8; j++)
            for (int e = 1; e < 16; e++) begin
                hit = 1'b1;
                for (int i = 0; i < 4; i++)
                    if (gmul(C[i][j], 4'(e)) != s[i]) hit = 1'b0;
                if (hit) return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [7:0][3:0] vp, input logic [3:0][3:0] pp,
                       input logic [7:0][3:0] evp, input logic [3:0][3:0] epp,
                       input logic ece, input logic edue, input logic [3:0] epos,
                       input int elat, input int hold, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(p_in_ready), 64'd1);
        in_vp = vp;
        in_pp = pp;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!p_out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(elat));
        chk({tag, ".vp"}, 64'(p_vp), 64'(evp));
        chk({tag, ".pp"}, 64'(p_pp), 64'(epp));
        chk({tag, ".ce_due_pos"}, 64'({p_ce, p_due, p_pos}), 64'({ece, edue, epos}));
        if (edue) begin
            chk({tag, ".z_vp_pp"}, 64'({z_vp, z_pp}), 64'd0);
            chk({tag, ".z_due_valid"}, 64'({z_due, z_out_valid}), 64'b11);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid_ready"}, 64'({p_out_valid, p_in_ready}), 64'b10);
            chk({tag, ".hold_data"}, 64'({p_vp, p_pp, p_ce, p_pos}), 64'({evp, epp, ece, epos}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".release"}, 64'({p_out_valid, p_in_ready}), 64'b01);
    endtask

    initial begin
        logic [7:0][3:0] vp, rvp;
        logic [3:0][3:0] pp, rpp, s;
        logic [3:0]      e, e1, e2;
        bit              found;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset.ready_valid", 64'({p_in_ready, p_out_valid}), 64'b10);
        chk("reset.flags_pos", 64'({p_ce, p_due, p_pos}), 64'h0F);
        chk("reset.data", 64'({p_vp, p_pp}), 64'd0);

        run('0, '0, '0, '0, 1'b0, 1'b0, 4'd15, 2, 0, "zero");

        pp = '0; pp[2] = 4'h5;
        run('0, pp, '0, '0, 1'b1, 1'b0, 4'd10, 2, 0, "pp2_err");

        vp = '0; vp[3] = 4'h1;
        run(vp, '0, '0, '0, 1'b1, 1'b0, 4'd3, 6, 0, "vp3_err");

        for (int p = 0; p < 12; p++) begin
            vp  = 32'($urandom);
            pp  = parity(vp);
            rvp = vp;
            rpp = pp;
            e   = 4'($urandom_range(1, 15));
            if (p < 8) rvp[p] = rvp[p] ^ e;
            else       rpp[p - 8] = rpp[p - 8] ^ e;
            run(rvp, rpp, vp, pp, 1'b1, 1'b0, 4'(p), (p < 8) ? 3 + p : 2, 0,
                $sformatf("rand_pos%0d", p));
        end

        found = 1'b0;
        e1 = 4'h1;
        e2 = 4'h1;
        for (int a = 1; a < 16 && !found; a++)
            for (int b = 1; b < 16 && !found; b++) begin
                for (int i = 0; i < 4; i++)
                    s[i] = gmul(C[i][0], 4'(a)) ^ gmul(C[i][1], 4'(b));
                if (!correctable(s)) begin
                    found = 1'b1;
                    e1 = 4'(a);
                    e2 = 4'(b);
                end
            end
        vp  = 32'($urandom);
        pp  = parity(vp);
        rvp = vp;
        rvp[0] = rvp[0] ^ e1;
        rvp[1] = rvp[1] ^ e2;
        run(rvp, pp, rvp, pp, 1'b0, 1'b1, 4'd15, 10, 0, "due_double");

        pp = '0; pp[0] = 4'h3;
        run('0, pp, '0, '0, 1'b1, 1'b0, 4'd8, 2, 5, "backpressure");

        // Column-7 error keeps the block in SEARCH long enough to reset it there
        vp = '0; vp[7] = 4'h9;
        @(negedge clk);
        in_vp = vp;
        in_pp = '0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset.valid_ready", 64'({p_out_valid, p_in_ready}), 64'b01);
        chk("midreset.flags_pos", 64'({p_ce, p_due, p_pos}), 64'h0F);
        @(negedge clk);
        rst_n = 1'b1;

        run('0, '0, '0, '0, 1'b0, 1'b0, 4'd15, 2, 0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
